// File: rtl/pc_seq.sv
// -----------------------------------------------------------------------------
// pc_seq -- parametrised program counter for the front of the fetch path.
//
// The PC advances once every CPI non-stalled clock cycles (an "advance
// event"). On an advance event exactly one action is taken, chosen by fixed
// priority: ret, call, abs_jump, rel_jump, then plain increment. call/ret use
// a small LIFO of return addresses; misuse of the stack raises sticky flags.
//
// Parameters:
//   D           PC / target width in bits
//   CPI         clock cycles per PC advance (>= 1)
//   OFFS_W      relative-jump offset width (two's complement)
//   STACK_DEPTH return-address stack entries (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset (0 = reset), highest priority
//   stall      in   freezes phase counter and PC while high
//   abs_jump   in   absolute jump request (prog_ctr <= target)
//   rel_jump   in   relative jump request (prog_ctr <= prog_ctr + offset)
//   call       in   push prog_ctr+1, then jump to target
//   ret        in   pop return address into prog_ctr
//   target     in   [D-1:0] absolute jump/call destination
//   offset     in   [OFFS_W-1:0] signed relative offset
//   prog_ctr   out  [D-1:0] current program counter (registered)
//   step       out  one-cycle pulse, high in the cycle after prog_ctr updates
//   stack_ovf  out  sticky: call attempted with stack full
//   stack_unf  out  sticky: ret attempted with stack empty
//
// Control inputs are only looked at on the advance-event cycle; whatever they
// carry on any other cycle is ignored, and lower-priority requests that lose
// arbitration are dropped rather than queued.
// -----------------------------------------------------------------------------
module pc_seq #(
    parameter int D           = 12,
    parameter int CPI         = 10,
    parameter int OFFS_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              abs_jump,
    input  logic              rel_jump,
    input  logic              call,
    input  logic              ret,
    input  logic [D-1:0]      target,
    input  logic [OFFS_W-1:0] offset,
    output logic [D-1:0]      prog_ctr,
    output logic              step,
    output logic              stack_ovf,
    output logic              stack_unf
);

    // -------------------------------------------------------------------------
    // Derived widths
    // -------------------------------------------------------------------------
    // Phase counter: clog2(CPI) bits, never narrower than one bit.
    localparam int PW  = (CPI > 1) ? $clog2(CPI) : 1;
    // Stack pointer must represent 0..STACK_DEPTH inclusive.
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    // Index into the entry array; the array is rounded up to 2**IW entries so
    // the index width matches the array exactly. Entries at or above
    // STACK_DEPTH are never written or read.
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [PW-1:0]  PH_LAST = PW'(CPI - 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [D-1:0]   PC_ONE  = D'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0]  phase;
    logic [SPW-1:0] sp;
    logic           step_pend;   // advance happened last edge; step follows
    logic [D-1:0]   stack_mem [2**IW];

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic           advance;
    logic [D-1:0]   pc_inc;
    logic [D-1:0]   offs_ext;
    logic [IW-1:0]  push_idx;
    logic [IW-1:0]  top_idx;
    logic           stack_empty;
    logic           stack_full;

    // Next-state values produced by the action arbiter
    logic [D-1:0]   pc_nxt;
    logic [SPW-1:0] sp_nxt;
    logic           push_en;
    logic           ovf_set;
    logic           unf_set;

    assign advance     = (phase == PH_LAST) && !stall;
    assign pc_inc      = prog_ctr + PC_ONE;
    // A size cast of a signed operand sign-extends when widening and truncates
    // when narrowing, which covers both OFFS_W < D and OFFS_W > D.
    assign offs_ext    = D'($signed(offset));
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_FULL);
    assign push_idx    = IW'(sp);
    assign top_idx     = IW'(sp - SP_ONE);

    // -------------------------------------------------------------------------
    // Action arbiter: exactly one action per advance event.
    // -------------------------------------------------------------------------
    always_comb begin
        pc_nxt  = prog_ctr;
        sp_nxt  = sp;
        push_en = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (advance) begin
            if (ret) begin
                // ret beats call, so a simultaneous call never pushes.
                if (!stack_empty) begin
                    pc_nxt = stack_mem[top_idx];
                    sp_nxt = sp - SP_ONE;
                end else begin
                    pc_nxt  = pc_inc;
                    unf_set = 1'b1;
                end
            end else if (call) begin
                // The jump happens whether or not the push fits.
                pc_nxt = target;
                if (!stack_full) begin
                    push_en = 1'b1;
                    sp_nxt  = sp + SP_ONE;
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (abs_jump) begin
                pc_nxt = target;
            end else if (rel_jump) begin
                pc_nxt = prog_ctr + offs_ext;
            end else begin
                pc_nxt = pc_inc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Phase counter, PC, stack pointer, step pipeline and sticky flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase     <= '0;
            prog_ctr  <= '0;
            sp        <= '0;
            step_pend <= 1'b0;
            step      <= 1'b0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            if (!stall) begin
                if (phase == PH_LAST) begin
                    phase <= '0;
                end else begin
                    phase <= phase + PW'(1);
                end
            end

            prog_ctr <= pc_nxt;
            sp       <= sp_nxt;

            // prog_ctr updates on the advance edge; step is asserted for the
            // whole cycle after the one in which the new value first appears.
            step_pend <= advance;
            step      <= step_pend;

            if (ovf_set) begin
                stack_ovf <= 1'b1;
            end
            if (unf_set) begin
                stack_unf <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Return-address storage. Contents are not reset (pointer reset is enough
    // to make them unreachable); the write is gated by reset so a call on the
    // reset edge leaves nothing behind.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset && push_en) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_pc_seq -- directed bench for pc_seq.
//
// Three instances share one clock and one reset:
//   u_c10 : D=12, CPI=10, OFFS_W=8, STACK_DEPTH=4  (free-run, priority, stall,
//           mid-operation reset)
//   u_c1  : D=12, CPI=1,  OFFS_W=8, STACK_DEPTH=2  (relative jumps, wrap,
//           call/return with overflow and underflow)
//   u_w   : D=4,  CPI=1,  OFFS_W=8, STACK_DEPTH=1  (free-running wrap 15 -> 0)
//
// Inputs change #1 after a rising edge and outputs are sampled at that same
// point, so every sample reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_pc_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // u_c10 stimulus / observation
    logic        a_stall, a_abs, a_rel, a_call, a_ret;
    logic [11:0] a_target;
    logic [7:0]  a_offset;
    logic [11:0] a_pc;
    logic        a_step, a_ovf, a_unf;

    // u_c1 stimulus / observation
    logic        b_stall, b_abs, b_rel, b_call, b_ret;
    logic [11:0] b_target;
    logic [7:0]  b_offset;
    logic [11:0] b_pc;
    logic        b_step, b_ovf, b_unf;

    // u_w observation (inputs tied idle)
    logic [3:0]  w_pc;
    logic        w_step, w_ovf, w_unf;

    int n_checks = 0;
    int n_pass   = 0;

    pc_seq #(.D(12), .CPI(10), .OFFS_W(8), .STACK_DEPTH(4)) u_c10 (
        .clk(clk), .reset(reset), .stall(a_stall), .abs_jump(a_abs),
        .rel_jump(a_rel), .call(a_call), .ret(a_ret), .target(a_target),
        .offset(a_offset), .prog_ctr(a_pc), .step(a_step),
        .stack_ovf(a_ovf), .stack_unf(a_unf)
    );

    pc_seq #(.D(12), .CPI(1), .OFFS_W(8), .STACK_DEPTH(2)) u_c1 (
        .clk(clk), .reset(reset), .stall(b_stall), .abs_jump(b_abs),
        .rel_jump(b_rel), .call(b_call), .ret(b_ret), .target(b_target),
        .offset(b_offset), .prog_ctr(b_pc), .step(b_step),
        .stack_ovf(b_ovf), .stack_unf(b_unf)
    );

    pc_seq #(.D(4), .CPI(1), .OFFS_W(8), .STACK_DEPTH(1)) u_w (
        .clk(clk), .reset(reset), .stall(1'b0), .abs_jump(1'b0),
        .rel_jump(1'b0), .call(1'b0), .ret(1'b0), .target(4'h0),
        .offset(8'h00), .prog_ctr(w_pc), .step(w_step),
        .stack_ovf(w_ovf), .stack_unf(w_unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        reset    = 1'b0;
        a_stall  = 0; a_abs = 0; a_rel = 0; a_call = 0; a_ret = 0;
        a_target = '0; a_offset = '0;
        b_stall  = 0; b_abs = 0; b_rel = 0; b_call = 0; b_ret = 0;
        b_target = '0; b_offset = '0;

        // ---------------- reset state ----------------
        ticks(2);
        check("rst_pc",   a_pc,   0);
        check("rst_step", a_step, 0);
        check("rst_ovf",  a_ovf,  0);
        check("rst_unf",  a_unf,  0);
        check("rst_c1_pc", b_pc,  0);

        // ---------------- free run, CPI=10 (and D=4 wrap) ----------------
        // Edge k after release: pc = k/10, step high at k = 11, 21, 31.
        reset = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            check($sformatf("run_pc_k%0d", k), a_pc, k / 10);
            check($sformatf("run_step_k%0d", k), a_step,
                  ((k % 10 == 1) && (k > 1)) ? 1 : 0);
            if (k >= 14 && k <= 17)
                check($sformatf("wrap4_pc_k%0d", k), w_pc, k % 16);
        end
        check("run_ovf", a_ovf, 0);
        check("run_unf", a_unf, 0);
        check("wrap4_ovf", w_ovf, 0);
        check("wrap4_unf", w_unf, 0);

        // ---------------- priority: ret+call+abs with empty stack --------------
        reset = 1'b0; tick(); reset = 1'b1;
        ticks(9);                          // phase 9: next edge is an advance
        check("prio_pre_pc", a_pc, 0);
        a_ret = 1; a_call = 1; a_abs = 1; a_target = 12'd100;
        tick();
        a_ret = 0; a_call = 0; a_abs = 0;
        check("prio_pc",  a_pc,  1);
        check("prio_unf", a_unf, 1);
        check("prio_ovf", a_ovf, 0);
        // Nothing was pushed, so another ret still underflows and increments.
        ticks(9);
        a_ret = 1;
        tick();
        a_ret = 0;
        check("prio_nopush_pc", a_pc, 2);
        check("prio_unf_sticky", a_unf, 1);

        // ---------------- stall delays the advance by 3 cycles --------------
        ticks(5);                          // phase 5
        a_stall = 1; a_abs = 1; a_target = 12'd77;
        ticks(3);                          // phase frozen at 5, abs ignored
        check("stall_hold_pc", a_pc, 2);
        a_stall = 0; a_abs = 0;
        ticks(4);                          // phase 9, still no advance
        check("stall_late_pc", a_pc, 2);
        tick();
        check("stall_adv_pc", a_pc, 3);
        check("stall_adv_step0", a_step, 0);
        tick();
        check("stall_step1", a_step, 1);
        tick();
        check("stall_step_clr", a_step, 0);
        ticks(7);                          // phase 9
        a_stall = 1; a_abs = 1; a_target = 12'd200;
        tick();
        check("stall_on_adv_pc", a_pc, 3);
        a_stall = 0;
        tick();
        a_abs = 0;
        check("abs_pc", a_pc, 200);

        // ---------------- reset on an advance edge carrying call ------------
        ticks(9);                          // phase 9
        a_call = 1; a_target = 12'd50; reset = 1'b0;
        tick();
        check("midrst_pc",   a_pc,   0);
        check("midrst_unf",  a_unf,  0);
        check("midrst_ovf",  a_ovf,  0);
        check("midrst_step", a_step, 0);
        reset = 1'b1; a_call = 0;
        tick();
        check("midrst_step_next", a_step, 0);
        check("midrst_pc_next",   a_pc,   0);
        ticks(8);                          // phase 9
        a_ret = 1;
        tick();
        a_ret = 0;
        check("midrst_empty_pc",  a_pc,  1);
        check("midrst_empty_unf", a_unf, 1);

        // ---------------- relative jumps, CPI=1 ----------------
        b_abs = 1; b_target = 12'd5;
        tick();
        b_abs = 0;
        check("rel_start_pc", b_pc, 5);
        b_rel = 1; b_offset = 8'hF9;       // -7
        tick();
        check("rel_neg_pc", b_pc, 12'hFFE);
        b_offset = 8'h03;
        tick();
        check("rel_pos_pc", b_pc, 12'h001);
        b_offset = 8'h7F;
        tick();
        check("rel_max_pc", b_pc, 12'h080);
        b_offset = 8'h80;                  // -128
        tick();
        b_rel = 0;
        check("rel_min_pc", b_pc, 12'h000);
        tick();
        check("c1_inc_pc", b_pc, 12'h001);
        check("c1_step", b_step, 1);
        b_abs = 1; b_target = 12'hFFF;
        tick();
        b_abs = 0;
        check("wrap12_top", b_pc, 12'hFFF);
        tick();
        check("wrap12_zero", b_pc, 12'h000);

        // ---------------- call/return, STACK_DEPTH=2 ----------------
        b_abs = 1; b_target = 12'd3;
        tick();
        b_abs = 0;
        check("cr_start", b_pc, 3);
        b_call = 1; b_target = 12'd40;
        tick();
        check("cr_call1", b_pc, 40);
        b_target = 12'd80;
        tick();
        check("cr_call2", b_pc, 80);
        check("cr_ovf_pre", b_ovf, 0);
        b_target = 12'd90;
        tick();
        b_call = 0;
        check("cr_call3_pc", b_pc, 90);
        check("cr_ovf", b_ovf, 1);
        b_ret = 1;
        tick();
        check("cr_ret1", b_pc, 41);
        tick();
        check("cr_ret2", b_pc, 4);
        check("cr_unf_pre", b_unf, 0);
        tick();
        b_ret = 0;
        check("cr_ret3_pc", b_pc, 5);
        check("cr_unf", b_unf, 1);
        check("cr_ovf_sticky", b_ovf, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
